// File: rtl/tel_line_scheduler_if.sv
// Bundle of request, line-status and grant/pulse signals between the subscriber
// side (master) and the line scheduler (slave).
interface tel_line_scheduler_if #(
  parameter int N     = 4,
  parameter int CNT_W = 8
);
  logic [N-1:0]       req;
  logic [N-1:0]       hangup;
  logic               line_idle;
  logic [N-1:0]       grant;
  logic               start_call;
  logic               end_call;
  logic               busy;
  logic               timeout_err;
  logic [N*CNT_W-1:0] served_cnt;

  modport master (
    output req, hangup, line_idle,
    input  grant, start_call, end_call, busy, timeout_err, served_cnt
  );

  modport slave (
    input  req, hangup, line_idle,
    output grant, start_call, end_call, busy, timeout_err, served_cnt
  );
endinterface

// File: rtl/tel_line_scheduler.sv
// Round-robin owner of a single telephone line: grants one subscriber at a time,
// pulses start/end to the line, and enforces start timeout, session cap and cooldown.
module tel_line_scheduler #(
  parameter int N             = 4,
  parameter int SESSION_MAX   = 1000,
  parameter int START_TIMEOUT = 16,
  parameter int COOLDOWN      = 4,
  parameter int CNT_W         = 8
) (
  input  logic                clk,
  input  logic                rst,
  tel_line_scheduler_if.slave sched_if
);

  localparam int PTR_W   = $clog2(N);
  localparam int TMAX_A  = (SESSION_MAX > START_TIMEOUT) ? SESSION_MAX : START_TIMEOUT;
  localparam int TMAX    = (TMAX_A > COOLDOWN) ? TMAX_A : COOLDOWN;
  localparam int TIMER_W = $clog2(TMAX + 1);

  localparam logic [TIMER_W-1:0] START_LAST   = TIMER_W'(START_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] SESSION_LAST = TIMER_W'(SESSION_MAX - 1);
  localparam logic [TIMER_W-1:0] COOL_LAST    = TIMER_W'(COOLDOWN - 1);
  localparam logic [CNT_W-1:0]   CNT_SAT      = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_START,
    S_ACTIVE,
    S_RELEASE,
    S_COOL
  } state_e;

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [N-1:0]       grant_q, grant_d;
  logic               start_call_q, start_call_d;
  logic               end_call_q, end_call_d;
  logic               timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0]   served_q [N];
  logic [CNT_W-1:0]   served_d [N];

  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  logic               owner_req;
  logic               owner_hang;
  logic               inc_served;
  logic [N*CNT_W-1:0] served_flat;

  // Rotating priority: search starts just after the last winner and wraps.
  always_comb begin : arbiter
    logic [PTR_W-1:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int off = 1; off <= N; off++) begin
      cand = PTR_W'((int'(rr_ptr_q) + off) % N);
      if (!win_found && sched_if.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // rr_ptr_q doubles as the owner index while the line is granted.
  assign owner_req  = sched_if.req[rr_ptr_q];
  assign owner_hang = sched_if.hangup[rr_ptr_q];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      timer_q       <= '0;
      rr_ptr_q      <= PTR_W'(N - 1);
      grant_q       <= '0;
      start_call_q  <= 1'b0;
      end_call_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      for (int i = 0; i < N; i++) served_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_q       <= grant_d;
      start_call_q  <= start_call_d;
      end_call_q    <= end_call_d;
      timeout_err_q <= timeout_err_d;
      for (int i = 0; i < N; i++) served_q[i] <= served_d[i];
    end
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin : next_state
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (win_found) state_d = S_WAIT_START;
      end
      S_WAIT_START: begin
        if (!sched_if.line_idle)      state_d = S_ACTIVE;
        else if (timer_q == START_LAST) state_d = S_COOL;
      end
      S_ACTIVE: begin
        if (sched_if.line_idle) state_d = S_COOL;
        else if (owner_hang || !owner_req || timer_q == SESSION_LAST) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (sched_if.line_idle) state_d = S_COOL;
      end
      S_COOL: begin
        if (timer_q == COOL_LAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin : outputs
    timer_d       = timer_q;
    rr_ptr_d      = rr_ptr_q;
    grant_d       = grant_q;
    start_call_d  = 1'b0;
    end_call_d    = 1'b0;
    timeout_err_d = 1'b0;
    inc_served    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          grant_d      = N'(1) << win_idx;
          rr_ptr_d     = win_idx;
          start_call_d = 1'b1;
          timer_d      = '0;
        end
      end
      S_WAIT_START: begin
        if (!sched_if.line_idle) begin
          timer_d = '0;
        end else if (timer_q == START_LAST) begin
          timeout_err_d = 1'b1;
          grant_d       = '0;
          timer_d       = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_ACTIVE: begin
        // The line hanging up on its own outranks any end request from us.
        if (sched_if.line_idle) begin
          grant_d    = '0;
          inc_served = 1'b1;
          timer_d    = '0;
        end else if (owner_hang || !owner_req || timer_q == SESSION_LAST) begin
          end_call_d = 1'b1;
          inc_served = 1'b1;
          timer_d    = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_RELEASE: begin
        if (sched_if.line_idle) begin
          grant_d = '0;
          timer_d = '0;
        end
      end
      S_COOL: begin
        timer_d = (timer_q == COOL_LAST) ? '0 : timer_q + 1'b1;
      end
      default: begin
        grant_d = '0;
        timer_d = '0;
      end
    endcase

    for (int i = 0; i < N; i++) served_d[i] = served_q[i];
    if (inc_served && served_q[rr_ptr_q] != CNT_SAT)
      served_d[rr_ptr_q] = served_q[rr_ptr_q] + 1'b1;
  end

  always_comb begin
    served_flat = '0;
    for (int i = 0; i < N; i++) served_flat[i*CNT_W +: CNT_W] = served_q[i];
  end

  assign sched_if.grant       = grant_q;
  assign sched_if.start_call  = start_call_q;
  assign sched_if.end_call    = end_call_q;
  assign sched_if.timeout_err = timeout_err_q;
  assign sched_if.busy        = (state_q != S_IDLE);
  assign sched_if.served_cnt  = served_flat;

endmodule

// File: tb/tb_tel_line_scheduler.sv
// Scoreboard bench for tel_line_scheduler: directed sessions push expected line
// events; a negedge monitor pops and compares them as the pulses appear.
module tb_tel_line_scheduler;

  localparam int N     = 4;
  localparam int CNT_W = 8;

  typedef enum int {EV_NONE, EV_START, EV_END, EV_TIMEOUT} ev_kind_e;

  typedef struct {
    ev_kind_e   kind;
    logic [3:0] grant;
    int         gap;   // cycles since previous event, -1 = don't care
  } exp_t;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   last_evt_cyc = 0;
  int   ev_idx   = 0;
  exp_t exp_q[$];

  tel_line_scheduler_if #(.N(N), .CNT_W(CNT_W)) sif ();

  tel_line_scheduler #(
    .N(N), .SESSION_MAX(1000), .START_TIMEOUT(16), .COOLDOWN(4), .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sched_if (sif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] onehot(input int i);
    return 4'(1 << i);
  endfunction

  function automatic logic [CNT_W-1:0] served_of(input int i);
    return sif.served_cnt[i*CNT_W +: CNT_W];
  endfunction

  task automatic push(input ev_kind_e k, input logic [3:0] g, input int gap);
    exp_t e;
    e.kind = k; e.grant = g; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_evt(input ev_kind_e k, input int max_cyc, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      tick(1);
      case (k)
        EV_START:   seen = sif.start_call;
        EV_END:     seen = sif.end_call;
        EV_TIMEOUT: seen = sif.timeout_err;
        default:    seen = 1'b0;
      endcase
    end
    check({name, "_seen"}, 64'(seen), 64'd1);
  endtask

  // Monitor: any line pulse must match the head of the expectation queue.
  always @(negedge clk) begin : monitor
    ev_kind_e k;
    exp_t     e;
    if (!rst && (sif.start_call || sif.end_call || sif.timeout_err)) begin
      k = sif.start_call ? EV_START : (sif.end_call ? EV_END : EV_TIMEOUT);
      if (exp_q.size() == 0) begin
        check($sformatf("ev%0d_unexpected_kind", ev_idx), 64'(k), 64'(EV_NONE));
      end else begin
        e = exp_q.pop_front();
        check($sformatf("ev%0d_kind", ev_idx), 64'(k), 64'(e.kind));
        check($sformatf("ev%0d_grant", ev_idx), 64'(sif.grant), 64'(e.grant));
        if (e.gap >= 0)
          check($sformatf("ev%0d_gap", ev_idx), 64'(cyc - last_evt_cyc), 64'(e.gap));
      end
      last_evt_cyc = cyc;
      ev_idx++;
    end
  end

  // Hangup by the owner 3 cycles into ACTIVE; line idles one cycle after end_call.
  task automatic rr_session(input int owner, input int start_gap);
    push(EV_START, onehot(owner), start_gap);
    push(EV_END,   onehot(owner), 4);
    wait_evt(EV_START, 40, $sformatf("rr_start%0d", owner));
    sif.line_idle = 1'b0;
    tick(3);
    sif.hangup = onehot(owner);
    tick(1);
    sif.hangup = '0;
    sif.line_idle = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    clk = 1'b0;
    rst = 1'b0;
    sif.req = '0;
    sif.hangup = '0;
    sif.line_idle = 1'b1;

    // Reset state
    #2 rst = 1'b1;
    #1;
    check("rst_grant", 64'(sif.grant), 64'd0);
    check("rst_busy", 64'(sif.busy), 64'd0);
    check("rst_pulses", 64'({sif.start_call, sif.end_call, sif.timeout_err}), 64'd0);
    check("rst_served", 64'(sif.served_cnt), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    tick(1);

    // Round robin with all requesting
    sif.req = 4'b1111;
    for (int s = 0; s < 5; s++) begin
      rr_session(s % 4, (s == 0) ? -1 : 6);
      if (s == 3)
        for (int i = 0; i < 4; i++) check($sformatf("rr_served%0d", i), 64'(served_of(i)), 64'd1);
    end
    sif.req = '0;
    tick(8);
    check("rr_idle_busy", 64'(sif.busy), 64'd0);
    check("rr_served0_final", 64'(served_of(0)), 64'd2);

    // Start timeout, twice
    sif.req = 4'b0100;
    push(EV_START, 4'b0100, -1);
    push(EV_TIMEOUT, 4'b0000, 16);
    push(EV_START, 4'b0100, 5);
    push(EV_TIMEOUT, 4'b0000, 16);
    wait_evt(EV_START, 20, "to_start1");
    wait_evt(EV_TIMEOUT, 20, "to_timeout1");
    check("to_grant_cleared", 64'(sif.grant), 64'd0);
    check("to_busy_cool", 64'(sif.busy), 64'd1);
    check("to_served2", 64'(served_of(2)), 64'd1);
    wait_evt(EV_START, 10, "to_start2");
    sif.req = '0;
    wait_evt(EV_TIMEOUT, 20, "to_timeout2");
    tick(6);
    check("to_idle_busy", 64'(sif.busy), 64'd0);
    check("to_served2_final", 64'(served_of(2)), 64'd1);

    // Session limit: line never idles, no hangup
    sif.req = 4'b0001;
    push(EV_START, 4'b0001, -1);
    push(EV_END, 4'b0001, 1001);
    wait_evt(EV_START, 20, "sm_start");
    sif.line_idle = 1'b0;
    wait_evt(EV_END, 1100, "sm_end");
    tick(3);
    check("sm_grant_held", 64'(sif.grant), 64'd1);
    check("sm_busy", 64'(sif.busy), 64'd1);
    check("sm_served0", 64'(served_of(0)), 64'd3);
    sif.line_idle = 1'b1;
    tick(1);
    check("sm_grant_released", 64'(sif.grant), 64'd0);
    sif.req = '0;
    tick(6);
    check("sm_idle_busy", 64'(sif.busy), 64'd0);

    // Owner 1: foreign hangup ignored; line idle beats owner hangup
    sif.req = 4'b0010;
    push(EV_START, 4'b0010, -1);
    wait_evt(EV_START, 20, "ow_start");
    sif.line_idle = 1'b0;
    tick(2);
    sif.hangup = 4'b0100;
    tick(1);
    sif.hangup = '0;
    check("ow_foreign_grant", 64'(sif.grant), 64'h2);
    check("ow_foreign_end", 64'(sif.end_call), 64'd0);
    sif.line_idle = 1'b1;
    sif.hangup = 4'b0010;
    tick(1);
    sif.hangup = '0;
    check("ow_both_grant", 64'(sif.grant), 64'd0);
    check("ow_both_end", 64'(sif.end_call), 64'd0);
    check("ow_both_busy", 64'(sif.busy), 64'd1);
    check("ow_served1", 64'(served_of(1)), 64'd2);
    sif.req = '0;
    tick(6);
    check("ow_served1_once", 64'(served_of(1)), 64'd2);
    check("ow_idle_busy", 64'(sif.busy), 64'd0);

    // Saturation of served_cnt[3] (starts at 1)
    sif.req = 4'b1000;
    for (int s = 0; s < 255; s++) begin
      push(EV_START, 4'b1000, (s == 0) ? -1 : 7);
      wait_evt(EV_START, 20, "sat_start");
      sif.line_idle = 1'b0;
      tick(1);
      sif.line_idle = 1'b1;
      tick(1);
      if (s == 253) check("sat_reach255", 64'(served_of(3)), 64'd255);
    end
    sif.req = '0;
    check("sat_hold255", 64'(served_of(3)), 64'd255);
    tick(8);
    check("sat_idle_busy", 64'(sif.busy), 64'd0);

    // Asynchronous reset in the middle of ACTIVE
    sif.req = 4'b0001;
    push(EV_START, 4'b0001, -1);
    wait_evt(EV_START, 20, "ra_start");
    sif.line_idle = 1'b0;
    tick(2);
    check("ra_grant_active", 64'(sif.grant), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("ra_grant", 64'(sif.grant), 64'd0);
    check("ra_busy", 64'(sif.busy), 64'd0);
    check("ra_pulses", 64'({sif.start_call, sif.end_call, sif.timeout_err}), 64'd0);
    check("ra_served", 64'(sif.served_cnt), 64'd0);
    sif.req = '0;
    sif.line_idle = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    tick(1);
    sif.req = 4'b0001;
    push(EV_START, 4'b0001, -1);
    push(EV_TIMEOUT, 4'b0000, 16);
    check("ra_grant_before", 64'(sif.grant), 64'd0);
    tick(1);
    check("ra_grant_after", 64'(sif.grant), 64'd1);
    sif.req = '0;
    wait_evt(EV_TIMEOUT, 20, "ra_timeout");
    tick(6);
    check("ra_idle_busy", 64'(sif.busy), 64'd0);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tel_line_scheduler.md
Name: tel_line_scheduler

Overview:
- Round-robin scheduler that shares one telephone line datapath (the call FSM with IDLE/RINGING/CALLER/CALLEE/REJECTED/COST behaviour) among N subscriber requesters.
- Grants the line to one requester at a time, issues the startCall/endCall pulses to the line, and enforces a start timeout, a session time limit and an inter-call cooldown.
- Keeps per-requester counters of completed sessions.
- Sits between the subscriber front-ends and the line instance.

Parameters:
- N, 4, number of requesters (2..8).
- SESSION_MAX, 1000, maximum ACTIVE cycles before the call is force-ended.
- START_TIMEOUT, 16, cycles allowed for the line to leave idle after start_call.
- COOLDOWN, 4, idle cycles enforced after each session before the next grant.
- CNT_W, 8, width of each served counter.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  N  level request per subscriber; bit i high = subscriber i wants the line.
- hangup  in  N  one-cycle hang-up pulse per subscriber.
- line_idle  in  1  high when the line FSM is in its IDLE state.
- grant  out  N  one-hot owner of the line; 0 when no owner.
- start_call  out  1  one-cycle pulse to the line's startCall.
- end_call  out  1  one-cycle pulse to the line's endCallCaller.
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  one-cycle pulse when the start timeout expires.
- served_cnt  out  N*CNT_W  per-requester completed-session counters; requester i in bits [i*CNT_W +: CNT_W].

Behaviour:
- Reset, asynchronous and immediate:
  - state=IDLE.
  - grant=0, start_call=0, end_call=0, timeout_err=0, busy=0.
  - served_cnt=0, timer=0.
  - rr_ptr=N-1, so requester 0 has first priority.
- States: IDLE, WAIT_START, ACTIVE, RELEASE, COOL.
- IDLE:
  - If req!=0, the winner is the first set req bit searching from (rr_ptr+1) mod N upward with wrap.
  - Next edge: grant=onehot(winner), rr_ptr=winner, start_call=1, timer=0, go to WAIT_START.
  - Latency: req high at edge k gives grant and start_call visible after edge k+1.
- start_call and end_call are high for exactly one cycle per assertion.
- WAIT_START:
  - If line_idle==0: go to ACTIVE, timer=0.
  - Else if timer==START_TIMEOUT-1: timeout_err pulse, grant=0, timer=0, go to COOL. No served_cnt increment.
  - Else timer+1.
- ACTIVE (priority high to low):
  - (a) line_idle==1, meaning the line ended the call itself: grant=0, served[owner]+1, go to COOL.
  - (b) hangup[owner]==1 or req[owner]==0: end_call pulse, served[owner]+1, go to RELEASE.
  - (c) timer==SESSION_MAX-1: end_call pulse, served[owner]+1, go to RELEASE.
  - (d) Otherwise timer+1.
  - hangup from non-owners is ignored.
- RELEASE:
  - grant is held.
  - When line_idle==1: grant=0, timer=0, go to COOL.
  - No timeout in this state.
- COOL:
  - After COOLDOWN cycles, return to IDLE: timer counts 0..COOLDOWN-1, exit on COOLDOWN-1.
  - req is ignored until back in IDLE.
- served_cnt saturates at 2^CNT_W-1 and never wraps.
- A requester that drops req before it is granted simply loses arbitration; there is no memory of past requests.
- The round-robin pointer advances only on a grant, never on a timeout.
- grant is always one-hot or zero.
- busy = (state!=IDLE) is registered from state.

Test Plan:
- Reset mid-ACTIVE with grant=0001 -> all outputs 0 in the same cycle as rst, served_cnt=0; after release, req=0001 -> grant=0001 two edges later.
- req=1111 held, each session ended by hangup on the owner 3 cycles into ACTIVE, line_idle returns 1 one cycle after end_call -> grant order 0001, 0010, 0100, 1000, 0001; consecutive grants separated by COOLDOWN=4 idle cycles; served_cnt each = 1 after four sessions.
- req=0100, line_idle held 1 -> start_call pulse, then timeout_err pulse exactly 16 cycles after WAIT_START entry; served_cnt[2]=0; next grant is again 0100 after cooldown.
- req=0001, line goes active and never idles, no hangup -> end_call pulse after SESSION_MAX=1000 ACTIVE cycles; grant held until line_idle=1; served_cnt[0]=1.
- In ACTIVE with owner 1: hangup=0100 -> ignored; line_idle=1 and hangup=0010 in the same cycle -> no end_call, state COOL, served_cnt[1]+1 exactly once.
- Preload served_cnt[3]=255 via 255 short sessions, then one more session -> stays 255.
